serial_bus_master: RTL
======================

// Module: serial_bus_master
// PURPOSE
//  UART-driven debug bus initiator. Receives 8N1 command frames on rxd and drives
//  the same 16-bit address/dout/rnw bus that the CPU drives, returning read data
//  and ACK/NAK bytes on txd. Sits beside the CPU in the system top.
//  The top uses bus_req to hold the CPU in reset and to mux this block onto the bus.
//  Used for RAM load, peek and poke without any CPU firmware.
// PARAMETERS
//  CLKSPEED      40000000  clk frequency, Hz
//  BAUD          115200    serial rate; DIV = CLKSPEED/BAUD, truncated (347 at defaults)
//  TIMEOUT_CYC   4000000   idle clk cycles inside a partial command before it is aborted
//  HALT_ON_RESET 1         reset value of bus_req
// PORTS
//  clk      in   1   system clock (one clock domain)
//  reset    in   1   synchronous, active-high reset
//  rxd      in   1   serial in, asynchronous, idle high
//  txd      out  1   serial out, idle high
//  bus_req  out  1   1 = this block owns the bus (top holds CPU reset and muxes bus)
//  address  out  16  bus address
//  dout     out  16  write data
//  din      in   16  read data from the system data mux
//  rnw      out  1   1 = read/idle, 0 = write strobe (one cycle)
//  overrun  out  1   sticky; RX byte overwritten before it was consumed
// BEHAVIOUR
//  Reset values: txd=1, rnw=1, address=0, dout=0, overrun=0, bus_req=HALT_ON_RESET.
//  Reset mid-frame, in either direction, aborts it; txd is high on the cycle after reset.
//  RX path:
//   - rxd passes through a 2-flop synchroniser.
//   - A falling edge starts a frame. Start bit is re-sampled at DIV/2; if high it is
//     a glitch and ignored.
//   - Data bits are sampled every DIV cycles thereafter, LSB first.
//   - Stop bit sampled low = framing error; the byte is discarded silently.
//   - A good byte loads rx_byte and sets rx_valid for the FSM.
//   - A new byte arriving while rx_valid=1 overwrites rx_byte and sets overrun.
//  TX path: start, 8 data bits LSB first, stop; DIV cycles per bit; one byte buffer.
//  Command set (all bytes MSB first):
//   'H' 0x48               -> bus_req=1, reply ACK 0x06
//   'G' 0x47               -> bus_req=0, reply ACK
//   'W' 0x57 aH aL dH dL   -> write, reply ACK
//   'R' 0x52 aH aL         -> read, reply dH dL
//   any other first byte   -> reply NAK 0x15
//  W or R with bus_req=0: all argument bytes are consumed, no bus cycle, reply NAK.
//  FSM states:
//   IDLE   -> decode the first byte.
//   ARG    -> collect N argument bytes (W:4, R:2). The timeout counter reloads on
//             every byte; on expiry go to IDLE with no reply.
//   WR     -> 1 cycle with address and dout valid, rnw=0; then REPLY.
//   RD1    -> address driven, rnw=1.
//   RD2    -> address held; din latched at the end of this cycle; then REPLY.
//   REPLY  -> send 1 or 2 bytes; return to IDLE after the last stop bit.
//  - Bytes are consumed only in IDLE and ARG. Bytes arriving in WR..REPLY stay
//    pending in rx_valid, subject to the overrun rule above.
//  - address and dout hold their last values outside bus cycles.
//  - rnw=0 for exactly one clk per W command and never otherwise.
//  - A W with bus_req=0 never drives rnw=0.
// TESTING (sim with CLKSPEED=1000000, BAUD=100000 -> DIV=10; RAM model on bus)
//  1 reset; send 57 00 10 BE EF -> one cycle rnw=0, address=0010, dout=BEEF; txd sends 06
//  2 then send 52 00 10 -> address=0010 for 2 cycles, rnw=1; txd sends BE then EF
//  3 send 47 -> bus_req=0, ACK 06; then 57 00 20 12 34 -> rnw stays 1, txd sends 15
//  4 send 00 in IDLE -> NAK 15; send 48 -> bus_req=1, ACK 06
//  5 send 57 00, idle > TIMEOUT_CYC -> no reply; then 52 00 10 -> BE EF
//  6 frame with stop bit 0 -> no reply, FSM stays IDLE; reset during reply -> txd=1 next clk

Source files
------------

// File: rtl/serial_bus_if.sv
// Debug/CPU system bus as seen by a bus initiator: address, write data, read data and strobe.
interface serial_bus_if;
    logic        bus_req;
    logic [15:0] address;
    logic [15:0] dout;
    logic [15:0] din;
    logic        rnw;

    modport master (output bus_req, address, dout, rnw, input din);
    modport slave  (input bus_req, address, dout, rnw, output din);
endinterface

// File: rtl/serial_bus_master.sv
// UART-driven debug bus initiator: 8N1 command frames on rxd become bus reads/writes,
// with read data and ACK/NAK bytes returned on txd.
module serial_bus_master #(
    parameter int unsigned CLKSPEED      = 40000000,
    parameter int unsigned BAUD          = 115200,
    parameter int unsigned TIMEOUT_CYC   = 4000000,
    parameter bit          HALT_ON_RESET = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rxd,
    output logic            txd,
    output logic            overrun,
    serial_bus_if.master    bus
);

    localparam int unsigned DIV = CLKSPEED / BAUD;
    localparam int unsigned CW  = $clog2(DIV + 1);
    localparam int unsigned TW  = $clog2(TIMEOUT_CYC + 1);

    localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);
    localparam logic [TW-1:0] TMO_M1  = TW'(TIMEOUT_CYC - 1);

    localparam logic [7:0] CH_H   = 8'h48;
    localparam logic [7:0] CH_G   = 8'h47;
    localparam logic [7:0] CH_W   = 8'h57;
    localparam logic [7:0] CH_R   = 8'h52;
    localparam logic [7:0] CH_ACK = 8'h06;
    localparam logic [7:0] CH_NAK = 8'h15;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARG,
        S_WR,
        S_RD1,
        S_RD2,
        S_REPLY
    } state_t;

    // ------------------------------------------------------------------ RX
    logic          rxd_s1, rxd_s2, rxd_q;
    logic          rx_busy;
    logic [CW-1:0] rx_cnt;
    logic [3:0]    rx_bit;
    logic [7:0]    rx_shift;
    logic [7:0]    rx_byte;
    logic          rx_valid;
    logic          rx_take_c;

    // Two-flop synchroniser plus one extra stage for falling-edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            rxd_s1 <= 1'b1;
            rxd_s2 <= 1'b1;
            rxd_q  <= 1'b1;
        end else begin
            rxd_s1 <= rxd;
            rxd_s2 <= rxd_s1;
            rxd_q  <= rxd_s2;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_busy  <= 1'b0;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_byte  <= '0;
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            if (rx_take_c)
                rx_valid <= 1'b0;
            if (!rx_busy) begin
                if (rxd_q && !rxd_s2) begin
                    rx_busy <= 1'b1;
                    rx_cnt  <= HALF_M1;
                    rx_bit  <= '0;
                end
            end else if (rx_cnt != '0) begin
                rx_cnt <= rx_cnt - CW'(1);
            end else begin
                rx_cnt <= DIV_M1;
                rx_bit <= rx_bit + 4'd1;
                if (rx_bit == 4'd0) begin
                    // start bit high again at mid-bit: line glitch
                    if (rxd_s2)
                        rx_busy <= 1'b0;
                end else if (rx_bit <= 4'd8) begin
                    rx_shift <= {rxd_s2, rx_shift[7:1]};
                end else begin
                    rx_busy <= 1'b0;
                    if (rxd_s2) begin
                        rx_byte  <= rx_shift;
                        rx_valid <= 1'b1;
                        if (rx_valid && !rx_take_c)
                            overrun <= 1'b1;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------ TX
    logic          tx_busy;
    logic [CW-1:0] tx_cnt;
    logic [3:0]    tx_bit;
    logic [8:0]    tx_shift;
    logic [7:0]    tx_buf;
    logic          tx_buf_valid;
    logic          tx_load_c;
    logic [7:0]    tx_data_c;

    // One-byte holding buffer feeding the shifter; start bit goes out on load
    always_ff @(posedge clk) begin
        if (reset) begin
            txd          <= 1'b1;
            tx_busy      <= 1'b0;
            tx_cnt       <= '0;
            tx_bit       <= '0;
            tx_shift     <= '1;
            tx_buf       <= '0;
            tx_buf_valid <= 1'b0;
        end else begin
            if (tx_load_c) begin
                tx_buf       <= tx_data_c;
                tx_buf_valid <= 1'b1;
            end
            if (!tx_busy) begin
                if (tx_buf_valid) begin
                    tx_busy      <= 1'b1;
                    tx_buf_valid <= 1'b0;
                    tx_shift     <= {1'b1, tx_buf};
                    tx_cnt       <= DIV_M1;
                    tx_bit       <= '0;
                    txd          <= 1'b0;
                end
            end else if (tx_cnt != '0) begin
                tx_cnt <= tx_cnt - CW'(1);
            end else if (tx_bit == 4'd9) begin
                tx_busy <= 1'b0;
                txd     <= 1'b1;
            end else begin
                txd      <= tx_shift[0];
                tx_shift <= {1'b1, tx_shift[8:1]};
                tx_bit   <= tx_bit + 4'd1;
                tx_cnt   <= DIV_M1;
            end
        end
    end

    // ------------------------------------------------------------------ command FSM
    state_t        state, state_d;
    logic          cmd_wr, cmd_wr_d;
    logic [2:0]    arg_left, arg_left_d;
    logic [31:0]   args, args_d;
    logic [31:0]   args_nxt;
    logic [TW-1:0] tmo, tmo_d;
    logic          bus_req_q, bus_req_d;
    logic [15:0]   address_q, address_d;
    logic [15:0]   dout_q, dout_d;
    logic          rnw_q, rnw_d;
    logic [15:0]   rep_data, rep_data_d;
    logic [1:0]    rep_left, rep_left_d;

    assign args_nxt = {args[23:0], rx_byte};

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            cmd_wr    <= 1'b0;
            arg_left  <= '0;
            args      <= '0;
            tmo       <= '0;
            bus_req_q <= HALT_ON_RESET;
            address_q <= '0;
            dout_q    <= '0;
            rnw_q     <= 1'b1;
            rep_data  <= '0;
            rep_left  <= '0;
        end else begin
            state     <= state_d;
            cmd_wr    <= cmd_wr_d;
            arg_left  <= arg_left_d;
            args      <= args_d;
            tmo       <= tmo_d;
            bus_req_q <= bus_req_d;
            address_q <= address_d;
            dout_q    <= dout_d;
            rnw_q     <= rnw_d;
            rep_data  <= rep_data_d;
            rep_left  <= rep_left_d;
        end
    end

    always_comb begin
        state_d    = state;
        cmd_wr_d   = cmd_wr;
        arg_left_d = arg_left;
        args_d     = args;
        tmo_d      = tmo;
        bus_req_d  = bus_req_q;
        address_d  = address_q;
        dout_d     = dout_q;
        rnw_d      = 1'b1;
        rep_data_d = rep_data;
        rep_left_d = rep_left;
        rx_take_c  = 1'b0;
        tx_load_c  = 1'b0;
        tx_data_c  = 8'h00;

        case (state)
            S_IDLE: begin
                if (rx_valid) begin
                    rx_take_c  = 1'b1;
                    rep_data_d = {CH_NAK, 8'h00};
                    rep_left_d = 2'd1;
                    state_d    = S_REPLY;
                    case (rx_byte)
                        CH_H: begin
                            bus_req_d  = 1'b1;
                            rep_data_d = {CH_ACK, 8'h00};
                        end
                        CH_G: begin
                            bus_req_d  = 1'b0;
                            rep_data_d = {CH_ACK, 8'h00};
                        end
                        CH_W, CH_R: begin
                            cmd_wr_d   = (rx_byte == CH_W);
                            arg_left_d = (rx_byte == CH_W) ? 3'd4 : 3'd2;
                            tmo_d      = TMO_M1;
                            rep_left_d = 2'd0;
                            state_d    = S_ARG;
                        end
                        default: ;
                    endcase
                end
            end
            S_ARG: begin
                if (rx_valid) begin
                    rx_take_c  = 1'b1;
                    args_d     = args_nxt;
                    arg_left_d = arg_left - 3'd1;
                    tmo_d      = TMO_M1;
                    if (arg_left == 3'd1) begin
                        // a halted-bus check here keeps a refused W from ever strobing rnw
                        if (!bus_req_q) begin
                            rep_data_d = {CH_NAK, 8'h00};
                            rep_left_d = 2'd1;
                            state_d    = S_REPLY;
                        end else if (cmd_wr) begin
                            address_d = args_nxt[31:16];
                            dout_d    = args_nxt[15:0];
                            rnw_d     = 1'b0;
                            state_d   = S_WR;
                        end else begin
                            address_d = args_nxt[15:0];
                            state_d   = S_RD1;
                        end
                    end
                end else if (tmo == '0) begin
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo - TW'(1);
                end
            end
            S_WR: begin
                rep_data_d = {CH_ACK, 8'h00};
                rep_left_d = 2'd1;
                state_d    = S_REPLY;
            end
            S_RD1: begin
                state_d = S_RD2;
            end
            S_RD2: begin
                rep_data_d = bus.din;
                rep_left_d = 2'd2;
                state_d    = S_REPLY;
            end
            S_REPLY: begin
                if (rep_left != 2'd0) begin
                    if (!tx_buf_valid) begin
                        tx_load_c  = 1'b1;
                        tx_data_c  = rep_data[15:8];
                        rep_data_d = {rep_data[7:0], 8'h00};
                        rep_left_d = rep_left - 2'd1;
                    end
                end else if (!tx_busy && !tx_buf_valid && !tx_load_c) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.bus_req = bus_req_q;
    assign bus.address = address_q;
    assign bus.dout    = dout_q;
    assign bus.rnw     = rnw_q;

endmodule
